// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage ALU and the multi-cycle divider.
package div_unit_pkg;

  localparam int DATA_W = 64;
  localparam int WORD_W = 32;
  localparam int CTRL_W = 5;

  localparam logic [CTRL_W-1:0] OP_DIV   = 5'b10011;
  localparam logic [CTRL_W-1:0] OP_DIVU  = 5'b10100;
  localparam logic [CTRL_W-1:0] OP_REM   = 5'b10101;
  localparam logic [CTRL_W-1:0] OP_REMU  = 5'b10110;
  localparam logic [CTRL_W-1:0] OP_DIVW  = 5'b11000;
  localparam logic [CTRL_W-1:0] OP_DIVUW = 5'b11001;
  localparam logic [CTRL_W-1:0] OP_REMW  = 5'b11010;
  localparam logic [CTRL_W-1:0] OP_REMUW = 5'b11011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic logic [DATA_W-1:0] sext_word(input logic [DATA_W-1:0] v);
    return {{(DATA_W-WORD_W){v[WORD_W-1]}}, v[WORD_W-1:0]};
  endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for the RV64M division group, with valid/ready
// request and response ports so the hazard unit can stall around it.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_W,
  parameter int WORD_WIDTH    = WORD_W,
  parameter int CONTROL_WIDTH = CTRL_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [CONTROL_WIDTH-1:0] div_control_i,
  input  logic [DATA_WIDTH-1:0]    src_1_i,
  input  logic [DATA_WIDTH-1:0]    src_2_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_WIDTH-1:0]    result_o,
  output logic                     busy_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_W = CNT_W'(WORD_WIDTH - 1);
  localparam int HI_W = DATA_WIDTH - WORD_WIDTH;

  div_state_e state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  out_valid_q, out_valid_d;
  logic                  word_q, word_d;
  logic                  is_rem_q, is_rem_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;

  logic                  op_known_s, op_signed_s, op_word_s, op_rem_s;
  logic [DATA_WIDTH-1:0] a_s, b_s, mag_a_s, mag_b_s, min_s;
  logic                  a_neg_s, b_neg_s, div_zero_s, overflow_s;
  logic [DATA_WIDTH-1:0] special_s;
  logic [DATA_WIDTH:0]   rem_shift_s;
  logic                  ge_s;
  logic [DATA_WIDTH-1:0] rem_sub_s;
  logic [DATA_WIDTH-1:0] quo_fix_s, rem_fix_s, sel_fix_s;

  // Operation decode.
  always_comb begin
    op_known_s  = 1'b1;
    op_signed_s = 1'b0;
    op_word_s   = 1'b0;
    op_rem_s    = 1'b0;
    case (div_control_i)
      OP_DIV:   begin op_signed_s = 1'b1; end
      OP_DIVU:  begin op_signed_s = 1'b0; end
      OP_REM:   begin op_signed_s = 1'b1; op_rem_s = 1'b1; end
      OP_REMU:  begin op_rem_s = 1'b1; end
      OP_DIVW:  begin op_signed_s = 1'b1; op_word_s = 1'b1; end
      OP_DIVUW: begin op_word_s = 1'b1; end
      OP_REMW:  begin op_signed_s = 1'b1; op_word_s = 1'b1; op_rem_s = 1'b1; end
      OP_REMUW: begin op_word_s = 1'b1; op_rem_s = 1'b1; end
      default:  begin op_known_s = 1'b0; end
    endcase
  end

  // Word operands are sign-extended so one magnitude/sign path serves both widths.
  always_comb begin
    a_s        = op_word_s ? sext_word(src_1_i) : src_1_i;
    b_s        = op_word_s ? sext_word(src_2_i) : src_2_i;
    a_neg_s    = op_signed_s & a_s[DATA_WIDTH-1];
    b_neg_s    = op_signed_s & b_s[DATA_WIDTH-1];
    mag_a_s    = a_neg_s ? (~a_s + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : a_s;
    mag_b_s    = b_neg_s ? (~b_s + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : b_s;
    min_s      = op_word_s ? {{(HI_W+1){1'b1}}, {(WORD_WIDTH-1){1'b0}}}
                           : {1'b1, {(DATA_WIDTH-1){1'b0}}};
    div_zero_s = (b_s == {DATA_WIDTH{1'b0}});
    overflow_s = op_signed_s & (a_s == min_s) & (b_s == {DATA_WIDTH{1'b1}});
    if (!op_known_s) begin
      special_s = {DATA_WIDTH{1'b0}};
    end else if (div_zero_s) begin
      special_s = op_rem_s ? a_s : {DATA_WIDTH{1'b1}};
    end else begin
      special_s = op_rem_s ? {DATA_WIDTH{1'b0}} : a_s;
    end
  end

  // One restoring step; the dividend is left-aligned so its MSB is always the top bit.
  always_comb begin
    rem_shift_s = {rem_q, dvd_q[DATA_WIDTH-1]};
    ge_s        = (rem_shift_s >= {1'b0, dvs_q});
    rem_sub_s   = ge_s ? DATA_WIDTH'(rem_shift_s - {1'b0, dvs_q})
                       : rem_shift_s[DATA_WIDTH-1:0];
    quo_fix_s   = neg_quo_q ? (~quo_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : quo_q;
    rem_fix_s   = neg_rem_q ? (~rem_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : rem_q;
    sel_fix_s   = is_rem_q ? rem_fix_s : quo_fix_s;
  end

  // Next-state and datapath control; flush wins over everything but reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    word_d      = word_q;
    is_rem_d    = is_rem_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    if (flush_i) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            word_d    = op_word_s;
            is_rem_d  = op_rem_s;
            neg_quo_d = a_neg_s ^ b_neg_s;
            neg_rem_d = a_neg_s;
            cnt_d     = {CNT_W{1'b0}};
            rem_d     = {DATA_WIDTH{1'b0}};
            quo_d     = {DATA_WIDTH{1'b0}};
            dvd_d     = op_word_s ? {mag_a_s[WORD_WIDTH-1:0], {HI_W{1'b0}}} : mag_a_s;
            dvs_d     = op_word_s ? {{HI_W{1'b0}}, mag_b_s[WORD_WIDTH-1:0]} : mag_b_s;
            if (!op_known_s || div_zero_s || overflow_s) begin
              result_d    = op_word_s ? sext_word(special_s) : special_s;
              out_valid_d = 1'b1;
              state_d     = DONE;
            end else begin
              state_d = CALC;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          rem_d = rem_sub_s;
          quo_d = {quo_q[DATA_WIDTH-2:0], ge_s};
          dvd_d = {dvd_q[DATA_WIDTH-2:0], 1'b0};
          if (cnt_q == (word_q ? LAST_W : LAST_D)) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        FIX: begin
          result_d    = word_q ? sext_word(sel_fix_s) : sel_fix_s;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      rem_q       <= {DATA_WIDTH{1'b0}};
      dvd_q       <= {DATA_WIDTH{1'b0}};
      dvs_q       <= {DATA_WIDTH{1'b0}};
      quo_q       <= {DATA_WIDTH{1'b0}};
      result_q    <= {DATA_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      word_q      <= 1'b0;
      is_rem_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      word_q      <= word_d;
      is_rem_q    <= is_rem_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors plus randomized operations
// checked against an arithmetic reference model.
module tb_div_unit;

  localparam logic [4:0] C_DIV   = 5'b10011;
  localparam logic [4:0] C_DIVU  = 5'b10100;
  localparam logic [4:0] C_REM   = 5'b10101;
  localparam logic [4:0] C_REMU  = 5'b10110;
  localparam logic [4:0] C_DIVW  = 5'b11000;
  localparam logic [4:0] C_DIVUW = 5'b11001;
  localparam logic [4:0] C_REMW  = 5'b11010;
  localparam logic [4:0] C_REMUW = 5'b11011;

  logic        clk_i, rst_i, flush_i, in_valid_i, in_ready_o;
  logic [4:0]  div_control_i;
  logic [63:0] src_1_i, src_2_i, result_o;
  logic        out_valid_o, out_ready_i, busy_o;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] last_exp = 64'd0;

  div_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .div_control_i(div_control_i), .src_1_i(src_1_i), .src_2_i(src_2_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: RISC-V division semantics from plain arithmetic.
  function automatic logic [63:0] model_res(input logic [4:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic known, sgn, word, isrem;
    logic [31:0] q32, r32;
    logic [63:0] q64, r64;
    int sa32, sb32;
    longint sa64, sb64;
    known = 1'b1; sgn = 1'b0; word = 1'b0; isrem = 1'b0;
    case (op)
      C_DIV:   sgn = 1'b1;
      C_DIVU:  ;
      C_REM:   begin sgn = 1'b1; isrem = 1'b1; end
      C_REMU:  isrem = 1'b1;
      C_DIVW:  begin sgn = 1'b1; word = 1'b1; end
      C_DIVUW: word = 1'b1;
      C_REMW:  begin sgn = 1'b1; word = 1'b1; isrem = 1'b1; end
      C_REMUW: begin word = 1'b1; isrem = 1'b1; end
      default: known = 1'b0;
    endcase
    if (!known) return 64'd0;
    if (word) begin
      sa32 = a[31:0]; sb32 = b[31:0];
      if (b[31:0] == 32'd0) begin q32 = 32'hFFFF_FFFF; r32 = a[31:0]; end
      else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        q32 = a[31:0]; r32 = 32'd0;
      end
      else if (sgn) begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
      else begin q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0]; end
      return isrem ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    sa64 = a; sb64 = b;
    if (b == 64'd0) begin q64 = '1; r64 = a; end
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q64 = a; r64 = 64'd0;
    end
    else if (sgn) begin q64 = sa64 / sb64; r64 = sa64 % sb64; end
    else begin q64 = a / b; r64 = a % b; end
    return isrem ? r64 : q64;
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
    logic word, sgn;
    word = (op == C_DIVW) || (op == C_DIVUW) || (op == C_REMW) || (op == C_REMUW);
    sgn  = (op == C_DIV) || (op == C_REM) || (op == C_DIVW) || (op == C_REMW);
    if (!(word || op == C_DIV || op == C_DIVU || op == C_REM || op == C_REMU)) return 1;
    if (word) begin
      if (b[31:0] == 32'd0) return 1;
      if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 34;
    end
    if (b == 64'd0) return 1;
    if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 66;
  endfunction

  function automatic logic [63:0] rnd_operand();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'hFFFF_FFFF_8000_0000;
      4: v = 64'($urandom_range(1, 100));
      5: v = -64'($urandom_range(1, 100));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic start_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk_i);
    vectors++;
    if (in_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL accept_ready: got %b expected 1", in_ready_o);
    end
    in_valid_i = 1'b1; div_control_i = op; src_1_i = a; src_2_i = b;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [63:0] exp, input int exp_lat);
    int lat;
    lat = 1;
    while (out_valid_o !== 1'b1 && lat < 100) begin
      vectors++;
      if (in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_busy: ready=%b busy=%b expected 0/1", name, in_ready_o, busy_o);
      end
      @(posedge clk_i); #1;
      lat++;
    end
    vectors++;
    if (out_valid_o !== 1'b1 || lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d (valid=%b) expected %0d", name, lat, out_valid_o, exp_lat);
    end
    vectors++;
    if (result_o !== exp) begin
      miscompares++; $display("FAIL %s_result: got %h expected %h", name, result_o, exp);
    end
    last_exp = exp;
  endtask

  task automatic handshake(input string name);
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    vectors++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_release: valid=%b ready=%b expected 0/1", name, out_valid_o, in_ready_o);
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    start_op(op, a, b);
    wait_result(name, exp, exp_lat);
    handshake(name);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    div_control_i = 5'd0; src_1_i = 64'd0; src_2_i = 64'd0;
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if (out_valid_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: valid=%b result=%h busy=%b ready=%b expected 0/0/0/1",
               out_valid_o, result_o, busy_o, in_ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_directed();
    run_op("div_20_m3", C_DIV, 64'd20, -64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
    run_op("rem_m20_3", C_REM, -64'd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run_op("remu_20_3", C_REMU, 64'd20, 64'd3, 64'd2, 66);
    run_op("divu_by0", C_DIVU, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_by0", C_REMU, 64'h1234, 64'd0, 64'h1234, 1);
    run_op("div_ovf", C_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", C_REM, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run_op("divw", C_DIVW, 64'hDEAD_BEEF_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 34);
    run_op("divuw", C_DIVUW, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_op("remw_by0", C_REMW, 64'h0000_0000_8000_0000, 64'h5555_0000_0000_0000,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("divu_big", C_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 66);
    run_op("bad_op", 5'b00001, 64'd99, 64'd7, 64'd0, 1);
  endtask

  task automatic test_backpressure();
    logic [63:0] exp;
    exp = model_res(C_DIV, 64'd1000, 64'd7);
    start_op(C_DIV, 64'd1000, 64'd7);
    wait_result("bp", exp, 66);
    repeat (10) begin
      @(posedge clk_i); #1;
      vectors++;
      if (out_valid_o !== 1'b1 || result_o !== exp || in_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold: valid=%b result=%h ready=%b expected 1/%h/0",
                 out_valid_o, result_o, in_ready_o, exp);
      end
    end
    handshake("bp");
    run_op("bp_next", C_REMUW, 64'd100, 64'd9, 64'd1, 34);
  endtask

  task automatic test_flush();
    logic [63:0] prev;
    bit seen_valid;
    prev = last_exp;
    start_op(C_DIV, 64'd123456789, 64'd11);
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_calc: busy=%b valid=%b ready=%b expected 0/0/1", busy_o, out_valid_o, in_ready_o);
    end
    seen_valid = 1'b0;
    repeat (70) begin
      @(posedge clk_i); #1;
      if (out_valid_o === 1'b1) seen_valid = 1'b1;
    end
    vectors++;
    if (seen_valid || result_o !== prev) begin
      miscompares++;
      $display("FAIL flush_discard: valid_seen=%b result=%h expected 0/%h", seen_valid, result_o, prev);
    end
    @(negedge clk_i);
    flush_i = 1'b1; in_valid_i = 1'b1; div_control_i = C_DIVU; src_1_i = 64'd50; src_2_i = 64'd0;
    @(posedge clk_i); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_drop: busy=%b valid=%b expected 0/0", busy_o, out_valid_o);
    end
    start_op(C_DIVU, 64'd77, 64'd0);
    wait_result("flush_done", '1, 1);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_in_done: busy=%b valid=%b expected 0/0", busy_o, out_valid_o);
    end
    run_op("flush_recover", C_DIVW, 64'd100, -64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 34);
  endtask

  task automatic test_reset_mid();
    start_op(C_REMU, 64'd999, 64'd10);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; flush_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b0 || result_o !== 64'd0) begin
      miscompares++;
      $display("FAIL rst_calc: busy=%b result=%h expected 0/0", busy_o, result_o);
    end
    start_op(C_DIVU, 64'd500, 64'd5);
    wait_result("rst_pre", 64'd100, 66);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    vectors++;
    if (out_valid_o !== 1'b0 || result_o !== 64'd0 || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_done: valid=%b result=%h ready=%b expected 0/0/1", out_valid_o, result_o, in_ready_o);
    end
  endtask

  task automatic test_random();
    logic [4:0] ops [9];
    logic [4:0] op;
    logic [63:0] a, b;
    ops = '{C_DIV, C_DIVU, C_REM, C_REMU, C_DIVW, C_DIVUW, C_REMW, C_REMUW, 5'b01010};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 8)];
      a = rnd_operand();
      b = rnd_operand();
      start_op(op, a, b);
      wait_result($sformatf("rnd%0d_op%b", i, op), model_res(op, a, b), model_lat(op, a, b));
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      handshake($sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = 64'($urandom_range(1, 1000));
      start_op(C_REM, a, b);
      wait_result($sformatf("b2b%0d", i), model_res(C_REM, a, b), 66);
      handshake($sformatf("b2b%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider for the RV64M division group: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW.
- Division is the inverse of the single-cycle multiplier in the execute stage. This block replaces the combinational "/" and "%" placeholders currently in the ALU.
- Sits beside the ALU in execute and uses the same 5-bit operation encoding.
- Has a valid/ready request port and a valid/ready response port, so the hazard unit can stall the pipeline while the block is busy.

Parameters:
- DATA_WIDTH, 64, operand and result width.
- WORD_WIDTH, 32, width used by the W-variants.
- CONTROL_WIDTH, 5, width of the operation code.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  kill any in-flight operation; pipeline flush.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  block can accept a request.
- div_control_i  in  CONTROL_WIDTH  operation code (ALU encoding).
- src_1_i  in  DATA_WIDTH  dividend.
- src_2_i  in  DATA_WIDTH  divisor.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  DATA_WIDTH  quotient or remainder.
- busy_o  out  1  state is not IDLE.

Behaviour:
- Clocking and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: state=IDLE, out_valid_o=0, result_o=0, busy_o=0, in_ready_o=1, iteration counter=0.
- Operation codes: DIV=10011, DIVU=10100, REM=10101, REMU=10110, DIVW=11000, DIVUW=11001, REMW=11010, REMUW=11011.
- Unsupported code: the request is accepted, result 0, handled on the special path.
- Request handshake: a request is accepted on an edge where in_valid_i && in_ready_o. in_ready_o = (state==IDLE).
- Operand capture at acceptance:
  - Word ops take bits [31:0] of each operand. The width N is 32, otherwise N is 64.
  - Signed ops record sign_q = dividend sign XOR divisor sign, and sign_r = dividend sign. Magnitudes (absolute values) are latched.
- Special path: the accepting edge goes straight to DONE with the result already computed.
  - Divisor (N bits) == 0: quotient = all ones, remainder = dividend.
  - Signed overflow (dividend = most-negative N-bit value, divisor = -1): quotient = dividend, remainder = 0.
- States:
  - IDLE: on accept, go to CALC, or to DONE on the special path.
  - CALC: radix-2 restoring divide, one quotient bit per edge, N edges.
    - Each edge: the partial remainder (N+1 bits) shifts left and takes the next dividend MSB.
    - If it is >= the divisor: subtract and shift in quotient bit 1, else shift in 0.
    - The counter counts 0..N-1. On the edge where the counter = N-1, go to FIX.
  - FIX: negate the quotient if sign_q, negate the remainder if sign_r (signed ops only). Select quotient or remainder.
    - Word ops: sign-extend bit 31 to 64 bits, including DIVUW and REMUW.
    - Register result_o and go to DONE with out_valid_o=1.
  - DONE: hold result_o and out_valid_o stable until out_ready_i. On the handshake edge go to IDLE with out_valid_o=0.
- Latency, counted from the accepting edge to out_valid_o high:
  - 66 edges for 64-bit ops.
  - 34 edges for word ops.
  - 1 edge on the special path.
- Throughput: one operation in flight. No new request is accepted in DONE. Back-to-back requests are 1 IDLE cycle apart.
- Flush:
  - flush_i in any state goes to IDLE on the next edge with out_valid_o=0, and any pending result is discarded.
  - flush_i has priority over a simultaneous accept: the request is dropped.
- Reset has priority over flush and over every other condition, including a reset in the middle of CALC.
- result_o changes only on entry to DONE or on reset.

Decomposition:
- Shared package holds the operation-code localparams, used by both the ALU and div_unit, and the state enum {IDLE, CALC, FIX, DONE}.
- No sub-module: the iteration step is a single subtract and shift inside this module.

Test Plan:
- DIV 20 / -3 → result 0xFFFF_FFFF_FFFF_FFFA (-6); out_valid_o rises exactly 66 edges after accept; in_ready_o=0 throughout.
- REM -20 % 3 → 0xFFFF_FFFF_FFFF_FFFE (-2). REMU 20 % 3 → 2.
- DIVU 0x1234 / 0 → all ones; REMU 0x1234 % 0 → 0x1234; both with 1-edge latency. DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000; REM of the same operands → 0.
- Word ops:
  - DIVW, src_1 = 0xDEAD_BEEF_8000_0000, src_2 = 2 → 0xFFFF_FFFF_C000_0000, latency 34.
  - DIVUW 0xFFFF_FFFF / 1 → 0xFFFF_FFFF_FFFF_FFFF.
  - REMW with divisor 0: low 32 bits are 0x8000_0000, result is 0xFFFF_FFFF_8000_0000.
- Backpressure: hold out_ready_i=0 for 10 cycles after out_valid_o → result_o and out_valid_o stay stable and in_ready_o stays 0. Release → IDLE the next edge and a new request is accepted.
- Flush and reset mid-operation:
  - flush_i at CALC iteration 20 → IDLE next edge, no out_valid_o. An accept coinciding with flush_i is dropped.
  - rst_i in DONE → out_valid_o=0 and result_o=0 on the next edge.
